// File: rtl/decoder_skid_stage_pkg.sv
// rtl/decoder_skid_stage_pkg.sv - shared types and constants for the decode stage
// Purpose: decoder_signals control bundle, opcode encodings, default widths and
//          the immediate sign-extension helper used by the decoder.
// Ports:   none (package).
package decoder_skid_stage_pkg;

  localparam int DEF_INSTR_W = 16;
  localparam int DEF_PC_W    = 24;
  localparam int DEF_IMM_W   = 16;
  localparam int DEF_PERF_W  = 16;

  typedef enum logic [3:0] {
    OP_LOAD  = 4'h8,
    OP_STORE = 4'h9,
    OP_BEQ   = 4'hA,
    OP_BNE   = 4'hB
  } opcode_e;

  // Opcodes at or above this value do not write a register.
  localparam logic [3:0] OP_NOWB_BASE = 4'hC;

  typedef struct packed {
    logic [3:0] opcode;
    logic [3:0] rd;
    logic [3:0] rs;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
  } decoder_signals;

  function automatic logic [DEF_IMM_W-1:0] sext8(input logic [7:0] v);
    return {{(DEF_IMM_W-8){v[7]}}, v};
  endfunction

endpackage

// File: rtl/decoder_skid_stage_if.sv
// rtl/decoder_skid_stage_if.sv - fetch-side and execute-side handshake bundle
// Purpose: groups the input (fetch) and output (execute) valid/ready streams.
// Ports:   in_valid/in_ready/instr_in/pc_in (fetch side),
//          out_valid/out_ready/control_signals_out/imm_out/pc_out (execute side).
//          master = environment view, slave = stage view.
interface decoder_skid_stage_if #(
  parameter int INSTR_W = 16,
  parameter int PC_W    = 24,
  parameter int IMM_W   = 16
) ();
  import decoder_skid_stage_pkg::*;

  logic               in_valid;
  logic               in_ready;
  logic [INSTR_W-1:0] instr_in;
  logic [PC_W-1:0]    pc_in;
  logic               out_valid;
  logic               out_ready;
  decoder_signals     control_signals_out;
  logic [IMM_W-1:0]   imm_out;
  logic [PC_W-1:0]    pc_out;

  modport master (
    output in_valid, instr_in, pc_in, out_ready,
    input  in_ready, out_valid, control_signals_out, imm_out, pc_out
  );

  modport slave (
    input  in_valid, instr_in, pc_in, out_ready,
    output in_ready, out_valid, control_signals_out, imm_out, pc_out
  );

endinterface

// File: rtl/decoder.sv
// rtl/decoder.sv - combinational instruction decoder
// Purpose: splits a 16-bit instruction into control signals and a sign-extended
//          8-bit immediate.
// Ports:   instr (in), sig (out, decoder_signals), imm (out).
module decoder
  import decoder_skid_stage_pkg::*;
(
  input  logic [DEF_INSTR_W-1:0] instr,
  output decoder_signals         sig,
  output logic [DEF_IMM_W-1:0]   imm
);

  logic [3:0] op;
  assign op = instr[15:12];

  always_comb begin
    sig           = '0;
    sig.opcode    = op;
    sig.rd        = instr[11:8];
    sig.rs        = instr[7:4];
    sig.reg_write = (op < OP_NOWB_BASE);
    sig.mem_read  = (op == OP_LOAD);
    sig.mem_write = (op == OP_STORE);
    sig.branch    = (op == OP_BEQ) || (op == OP_BNE);
    imm           = sext8(instr[7:0]);
  end

endmodule

// File: rtl/decoder_skid_stage_skid_buffer2.sv
// rtl/decoder_skid_stage_skid_buffer2.sv - generic 2-entry valid/ready register slice
// Purpose: head register drives the output, skid register absorbs the one extra
//          item accepted while the head is stalled; synchronous flush.
// Ports:   clk, rst, flush; in_valid/in_ready/in_data; out_valid/out_ready/out_data.
module skid_buffer2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         head_valid, skid_valid;
  logic [W-1:0] head_data, skid_data;
  logic         accept, drain;

  // Ready depends only on skid occupancy, so out_ready never reaches in_ready.
  assign in_ready  = !skid_valid;
  assign out_valid = head_valid;
  assign out_data  = head_data;
  assign accept    = in_valid && in_ready;
  assign drain     = head_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      head_valid <= 1'b0;
      skid_valid <= 1'b0;
      head_data  <= '0;
      skid_data  <= '0;
    end else if (flush) begin
      head_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (!head_valid) begin
      head_valid <= accept;
      head_data  <= in_data;
    end else if (drain) begin
      if (skid_valid) begin
        // accept is impossible here since in_ready is low while the skid is full.
        head_data  <= skid_data;
        skid_valid <= 1'b0;
      end else begin
        head_valid <= accept;
        head_data  <= in_data;
      end
    end else if (accept) begin
      skid_valid <= 1'b1;
      skid_data  <= in_data;
    end
  end

endmodule

// File: rtl/decoder_skid_stage.sv
// rtl/decoder_skid_stage.sv - registered decode stage with skid buffer and stall counter
// Purpose: decodes instr_in, stores {sig, imm, pc} in a 2-entry slice and counts
//          back-pressured output cycles with a saturating counter.
// Ports:   clk, rst (sync, active-high), flush, bus (slave modport of
//          decoder_skid_stage_if), stall_count (out, PERF_W).
module decoder_skid_stage
  import decoder_skid_stage_pkg::*;
#(
  parameter int INSTR_W = 16,
  parameter int PC_W    = 24,
  parameter int IMM_W   = 16,
  parameter int PERF_W  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  decoder_skid_stage_if.slave bus,
  output logic [PERF_W-1:0]   stall_count
);

  typedef struct packed {
    decoder_signals   sig;
    logic [IMM_W-1:0] imm;
    logic [PC_W-1:0]  pc;
  } stage_entry_t;

  localparam int ENTRY_W = $bits(stage_entry_t);

  logic [INSTR_W-1:0] instr;
  decoder_signals     dec_sig;
  logic [IMM_W-1:0]   dec_imm;
  stage_entry_t       in_entry, out_entry;

  assign instr = bus.instr_in;

  decoder u_decoder (
    .instr (instr),
    .sig   (dec_sig),
    .imm   (dec_imm)
  );

  assign in_entry = '{sig: dec_sig, imm: dec_imm, pc: bus.pc_in};

  skid_buffer2 #(.W(ENTRY_W)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (bus.in_valid),
    .in_ready  (bus.in_ready),
    .in_data   (in_entry),
    .out_valid (bus.out_valid),
    .out_ready (bus.out_ready),
    .out_data  (out_entry)
  );

  assign bus.control_signals_out = out_entry.sig;
  assign bus.imm_out             = out_entry.imm;
  assign bus.pc_out              = out_entry.pc;

  // A flush edge leaves the counter untouched even if the output was stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_count <= '0;
    end else if (!flush && bus.out_valid && !bus.out_ready && (stall_count != '1)) begin
      stall_count <= stall_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_decoder_skid_stage.sv
// tb/tb_decoder_skid_stage.sv - self-checking bench for decoder_skid_stage
module tb_decoder_skid_stage;
  import decoder_skid_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [15:0] stall;
  logic [3:0]  stall4;
  logic [15:0] sig_bits;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  decoder_skid_stage_if #(.INSTR_W(16), .PC_W(24), .IMM_W(16)) bif ();
  decoder_skid_stage_if #(.INSTR_W(16), .PC_W(24), .IMM_W(16)) bif4 ();

  assign bif4.in_valid  = bif.in_valid;
  assign bif4.instr_in  = bif.instr_in;
  assign bif4.pc_in     = bif.pc_in;
  assign bif4.out_ready = bif.out_ready;
  assign sig_bits       = bif.control_signals_out;

  decoder_skid_stage #(.INSTR_W(16), .PC_W(24), .IMM_W(16), .PERF_W(16)) dut (
    .clk (clk), .rst (rst), .flush (flush), .bus (bif), .stall_count (stall)
  );

  decoder_skid_stage #(.INSTR_W(16), .PC_W(24), .IMM_W(16), .PERF_W(4)) dut4 (
    .clk (clk), .rst (rst), .flush (flush), .bus (bif4), .stall_count (stall4)
  );

  typedef struct {
    logic [15:0] instr;
    logic [23:0] pc;
    logic [15:0] exp_sig;
    logic [15:0] exp_imm;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] ins, input logic [23:0] pc);
    bif.in_valid = v;
    bif.instr_in = ins;
    bif.pc_in    = pc;
  endtask

  // Reference decode: {opcode, rd, rs, wb, ld, st, br} and sign-extended low byte.
  function automatic logic [31:0] ref_dec(input logic [15:0] i);
    logic [3:0] op;
    logic [3:0] flags;
    op       = i[15:12];
    flags[3] = (op <= 4'hB);
    flags[2] = (op == 4'h8);
    flags[1] = (op == 4'h9);
    flags[0] = (op == 4'hA) || (op == 4'hB);
    return {op, i[11:8], i[7:4], flags, {8{i[7]}}, i[7:0]};
  endfunction

  task automatic check_head(input string name, input logic [15:0] ins, input logic [23:0] pc);
    check(name, 64'({sig_bits, bif.imm_out, bif.pc_out}), 64'({ref_dec(ins), pc}));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    flush = 1'b0;
    bif.out_ready = 1'b0;
    drive(1'b0, 16'h0, 24'h0);
    tick();
    rst = 1'b0;
  endtask

  logic [15:0] q_instr[$];
  logic [23:0] q_pc[$];

  initial begin
    vecs[0] = '{16'h1111, 24'h000000, 16'h1118, 16'h0011};
    vecs[1] = '{16'h1112, 24'h000002, 16'h1118, 16'h0012};
    vecs[2] = '{16'h1113, 24'h000004, 16'h1118, 16'h0013};
    vecs[3] = '{16'h1114, 24'h000006, 16'h1118, 16'h0014};
    vecs[4] = '{16'h8A95, 24'h000008, 16'h8A9C, 16'hFF95};
    vecs[5] = '{16'h93F0, 24'h00000A, 16'h93FA, 16'hFFF0};
    vecs[6] = '{16'hA07F, 24'h00000C, 16'hA079, 16'h007F};
    vecs[7] = '{16'hC480, 24'h00000E, 16'hC480, 16'hFF80};
    vecs[8] = '{16'hB000, 24'h000010, 16'hB009, 16'h0000};
    vecs[9] = '{16'hFFFF, 24'hFFFFFE, 16'hFFF0, 16'hFFFF};

    // Reset state.
    do_reset();
    check("rst_out_valid", 64'(bif.out_valid), 64'd0);
    check("rst_in_ready", 64'(bif.in_ready), 64'd1);
    check("rst_data", 64'({sig_bits, bif.imm_out, bif.pc_out}), 64'd0);
    check("rst_stall", 64'(stall), 64'd0);

    // Streaming with hand-computed decodes, out_ready held high.
    bif.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, vecs[i].instr, vecs[i].pc);
      check($sformatf("stream_in_ready_%0d", i), 64'(bif.in_ready), 64'd1);
      tick();
      check($sformatf("stream_valid_%0d", i), 64'(bif.out_valid), 64'd1);
      check($sformatf("stream_data_%0d", i), 64'({sig_bits, bif.imm_out, bif.pc_out}),
            64'({vecs[i].exp_sig, vecs[i].exp_imm, vecs[i].pc}));
    end
    drive(1'b0, 16'h0, 24'h0);
    tick();
    check("stream_drained", 64'(bif.out_valid), 64'd0);

    // Back-pressure: head=I0, skid=I1, I2 held until release.
    do_reset();
    drive(1'b1, 16'h2001, 24'h100);
    tick();
    check("bp_valid0", 64'(bif.out_valid), 64'd1);
    check("bp_ready_after1", 64'(bif.in_ready), 64'd1);
    drive(1'b1, 16'h2002, 24'h102);
    tick();
    check("bp_ready_full", 64'(bif.in_ready), 64'd0);
    check_head("bp_head_i0", 16'h2001, 24'h100);
    drive(1'b1, 16'h2003, 24'h104);
    tick();
    check("bp_ready_still0", 64'(bif.in_ready), 64'd0);
    check_head("bp_head_hold", 16'h2001, 24'h100);
    check("bp_stall2", 64'(stall), 64'd2);
    bif.out_ready = 1'b1;
    tick();
    check_head("bp_head_i1", 16'h2002, 24'h102);
    check("bp_ready_freed", 64'(bif.in_ready), 64'd1);
    tick();
    check_head("bp_head_i2", 16'h2003, 24'h104);
    drive(1'b0, 16'h0, 24'h0);
    tick();
    check("bp_empty", 64'(bif.out_valid), 64'd0);

    // Flush with both entries full and 0xBEEF offered.
    do_reset();
    drive(1'b1, 16'h3001, 24'h200);
    tick();
    drive(1'b1, 16'h3002, 24'h202);
    tick();
    check("fl_full", 64'(bif.in_ready), 64'd0);
    flush = 1'b1;
    drive(1'b1, 16'hBEEF, 24'h204);
    tick();
    flush = 1'b0;
    drive(1'b0, 16'h0, 24'h0);
    check("fl_out_valid", 64'(bif.out_valid), 64'd0);
    check("fl_in_ready", 64'(bif.in_ready), 64'd1);
    check("fl_stall_kept", 64'(stall), 64'd1);
    bif.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("fl_no_beef_%0d", i), 64'(bif.out_valid), 64'd0);
    end

    // Reset with both entries full.
    bif.out_ready = 1'b0;
    drive(1'b1, 16'h4001, 24'h300);
    tick();
    drive(1'b1, 16'h4002, 24'h302);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(1'b0, 16'h0, 24'h0);
    check("mr_out_valid", 64'(bif.out_valid), 64'd0);
    check("mr_imm_pc", 64'({bif.imm_out, bif.pc_out}), 64'd0);
    check("mr_stall", 64'(stall), 64'd0);
    check("mr_in_ready", 64'(bif.in_ready), 64'd1);
    bif.out_ready = 1'b1;
    tick();
    check("mr_no_output", 64'(bif.out_valid), 64'd0);

    // Stall counter and saturation on the 4-bit instance.
    do_reset();
    drive(1'b1, 16'h5001, 24'h400);
    tick();
    drive(1'b0, 16'h0, 24'h0);
    check("cnt_start", 64'(stall), 64'd0);
    repeat (10) tick();
    check("cnt_10", 64'(stall), 64'd10);
    check("cnt4_10", 64'(stall4), 64'd10);
    repeat (10) tick();
    check("cnt_20", 64'(stall), 64'd20);
    check("cnt4_sat", 64'(stall4), 64'd15);
    bif.out_ready = 1'b1;
    tick();
    check("cnt_no_inc_ready", 64'(stall), 64'd20);
    check("cnt4_hold", 64'(stall4), 64'd15);

    // Random traffic against a queue model.
    do_reset();
    begin
      logic        v, r, f, exp_ready;
      logic [15:0] ins;
      logic [23:0] pcv;
      pcv = 24'h0;
      for (int c = 0; c < 400; c++) begin
        v   = ($urandom_range(0, 9) < 7);
        r   = ($urandom_range(0, 9) < 6);
        f   = ($urandom_range(0, 99) < 5);
        ins = 16'($urandom);
        pcv = pcv + 24'd2;
        drive(v, ins, pcv);
        bif.out_ready = r;
        flush = f;
        exp_ready = (q_instr.size() < 2);
        check("rnd_in_ready", 64'(bif.in_ready), 64'(exp_ready));
        check("rnd_out_valid", 64'(bif.out_valid), 64'(q_instr.size() > 0));
        if (q_instr.size() > 0) check_head("rnd_head", q_instr[0], q_pc[0]);
        tick();
        if (f) begin
          q_instr.delete();
          q_pc.delete();
        end else begin
          if (q_instr.size() > 0 && r) begin
            void'(q_instr.pop_front());
            void'(q_pc.pop_front());
          end
          if (v && exp_ready) begin
            q_instr.push_back(ins);
            q_pc.push_back(pcv);
          end
        end
      end
      flush = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
